// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges EX (src0) and MEM (src1) results through per-source FIFOs
// into one registered register-file write per cycle, with a starvation guard for src1.
module wb_write_arbiter #(
  parameter int TAG_WIDTH    = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src0_valid,
  output logic                 src0_ready,
  input  logic [4:0]           src0_addr,
  input  logic [TAG_WIDTH-1:0] src0_tag,
  input  logic [31:0]          src0_data,
  input  logic                 src1_valid,
  output logic                 src1_ready,
  input  logic [4:0]           src1_addr,
  input  logic [TAG_WIDTH-1:0] src1_tag,
  input  logic [31:0]          src1_data,
  output logic                 wr_ch0_en,
  output logic [4:0]           wr_ch0_addr,
  output logic [TAG_WIDTH-1:0] wr_ch0_tag,
  output logic [31:0]          wr_ch0_data,
  output logic                 busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]           addr;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          data;
  } entry_t;

  entry_t [1:0]     in_entry;
  entry_t [1:0]     head;
  logic   [1:0]     in_valid;
  logic   [1:0]     full;
  logic   [1:0]     head_valid;
  logic   [1:0]     push;
  logic   [1:0]     grant;
  logic [STV_W-1:0] starve_cnt;

  assign in_entry[0] = {src0_addr, src0_tag, src0_data};
  assign in_entry[1] = {src1_addr, src1_tag, src1_data};
  assign in_valid    = {src1_valid, src0_valid};

  // Writes to r0 are accepted so the producer is not stalled, but never queued.
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full[i]       = (count == CNT_W'(FIFO_DEPTH));
    assign head_valid[i] = (count != '0);
    assign head[i]       = mem[rd_ptr];
    assign push[i]       = in_valid[i] & ~full[i] & (in_entry[i].addr != 5'd0);

    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem[wr_ptr] <= in_entry[i];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (grant[i]) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push[i]) - CNT_W'(grant[i]);
      end
    end
  end

  assign src0_ready = ~full[0];
  assign src1_ready = ~full[1];

  // src0 has priority unless src1 has lost STARVE_LIMIT arbitrations in a row.
  always_comb begin
    grant = '0;
    if (head_valid[0] && (!head_valid[1] || starve_cnt < STV_W'(STARVE_LIMIT))) begin
      grant[0] = 1'b1;
    end else if (head_valid[1]) begin
      grant[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant[1]) begin
      starve_cnt <= '0;
    end else if (head_valid[1] && grant[0] && starve_cnt != STV_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ch0_en   <= 1'b0;
      wr_ch0_addr <= '0;
      wr_ch0_tag  <= '0;
      wr_ch0_data <= '0;
    end else begin
      wr_ch0_en <= |grant;
      if (grant[0]) begin
        {wr_ch0_addr, wr_ch0_tag, wr_ch0_data} <= head[0];
      end else if (grant[1]) begin
        {wr_ch0_addr, wr_ch0_tag, wr_ch0_data} <= head[1];
      end
    end
  end

  assign busy = (|head_valid) | wr_ch0_en;

endmodule
